// File: rtl/i2s_rx_fifo.sv
// Receive-side stereo pair buffer for the I2S core: captures one left/right
// pair per completed frame from core state edges and queues it for a valid/ready consumer.
module i2s_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [2:0]    cst,
  input  logic [31:0]   dout_l,
  input  logic [31:0]   dout_r,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data_l,
  output logic [31:0]   m_data_r,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [2:0] {
    IDLE_R    = 3'd0,
    CHANNEL_R = 3'd1,
    START_R   = 3'd2,
    IDLE_L    = 3'd3,
    CHANNEL_L = 3'd4,
    START_L   = 3'd5
  } core_state_t;

  core_state_t cur;
  core_state_t cst_d;

  logic          have_l;
  logic [31:0]   hold_l;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic left_done;
  logic right_done;
  logic push_req;
  logic pop;
  logic accept;
  logic drop;

  assign cur        = core_state_t'(cst);
  assign left_done  = (cst_d == CHANNEL_L) && (cur == IDLE_L);
  assign right_done = (cst_d == CHANNEL_R) && (cur == IDLE_R);

  // A right word without a captured left word is an orphan and is simply ignored.
  assign push_req = right_done && enable && have_l;
  assign pop      = m_valid && m_ready;
  assign accept   = push_req && ((level < (AW+1)'(DEPTH)) || pop);
  assign drop     = push_req && !accept;

  assign m_valid  = (level != '0);
  assign m_data_l = mem[rd_ptr][63:32];
  assign m_data_r = mem[rd_ptr][31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cst_d  <= IDLE_R;
      have_l <= 1'b0;
      hold_l <= '0;
    end else begin
      cst_d <= cur;
      if (!enable) begin
        have_l <= 1'b0;
      end else if (left_done) begin
        hold_l <= dout_l;
        have_l <= 1'b1;
      end else if (right_done) begin
        have_l <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {hold_l, dout_r};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      level <= level + 1'b1;
      else if (pop && !accept) level <= level - 1'b1;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow)          drop_cnt <= 8'd1;
      else if (drop_cnt != '1)   drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Scoreboard bench for i2s_rx_fifo: frames are driven through core states,
// expected pairs are queued at drive time and compared when popped.
module tb_i2s_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  cst;
  logic [31:0] dout_l;
  logic [31:0] dout_r;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data_l;
  logic [31:0] m_data_r;
  logic [3:0]  level;
  logic        overflow;
  logic        clr_overflow;
  logic [7:0]  drop_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  i2s_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cst(cst),
    .dout_l(dout_l), .dout_r(dout_r),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data_l(m_data_l), .m_data_r(m_data_r),
    .level(level), .overflow(overflow),
    .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake is sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check_val("pop_unexpected", 64'd1, 64'd0);
      end else begin
        check_val("pop_data", {m_data_l, m_data_r}, sb.pop_front());
      end
    end
  end

  // One frame through start_l..idle_r; options act on particular state cycles.
  task automatic frame(input logic [31:0] l, input logic [31:0] r, input bit exp_push,
                       input bit drop_en, input bit pop_at_done, input bit clr_at_done);
    logic saved_ready;
    saved_ready = m_ready;
    dout_l = l;
    dout_r = r;
    for (int i = 5; i >= 0; i--) begin
      cst = 3'(i);
      enable = !(drop_en && i == 2);
      if (i == 0) begin
        if (pop_at_done) m_ready = 1'b1;
        clr_overflow = clr_at_done;
        if (exp_push) sb.push_back({l, r});
      end
      tick();
    end
    m_ready = saved_ready;
    clr_overflow = 1'b0;
    enable = 1'b1;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int n = 0; n < 20 && level != 0; n++) tick();
    check_val("drain_level", 64'(level), 64'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; cst = 3'd1; dout_l = '0; dout_r = '0;
    m_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) tick();
    check_val("rst_valid", 64'(m_valid), 64'd0);
    check_val("rst_level", 64'(level), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    check_val("rst_drop", 64'(drop_cnt), 64'd0);

    // Orphan right channel right after reset release.
    rst = 1'b0;
    dout_r = 32'hDEAD_BEEF;
    tick();
    cst = 3'd0;
    tick();
    check_val("orphan_level", 64'(level), 64'd0);
    frame(32'd1, 32'd2, 1, 0, 0, 0);
    check_val("orphan_first_level", 64'(level), 64'd1);
    check_val("orphan_first_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    tick();
    check_val("orphan_drained", 64'(level), 64'd0);

    // Basic capture with consumer always ready.
    for (int k = 0; k < 3; k++) begin
      frame(32'hA5A5_0001, 32'h5A5A_0002, 1, 0, 0, 0);
      check_val("basic_level1", 64'(level), 64'd1);
      tick();
      check_val("basic_level0", 64'(level), 64'd0);
      check_val("basic_valid0", 64'(m_valid), 64'd0);
    end

    // Fill to overflow.
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) frame(32'(k), 32'(k + 100), k < 8, 0, 0, 0);
    check_val("fill_level", 64'(level), 64'd8);
    check_val("fill_ovf", 64'(overflow), 64'd1);
    check_val("fill_drop", 64'(drop_cnt), 64'd2);

    // Clear alone.
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check_val("clr_ovf", 64'(overflow), 64'd0);
    check_val("clr_drop", 64'(drop_cnt), 64'd0);

    // Full with a pop in the push cycle: accepted, no overflow.
    frame(32'd200, 32'd300, 1, 0, 1, 0);
    check_val("fullpop_level", 64'(level), 64'd8);
    check_val("fullpop_ovf", 64'(overflow), 64'd0);

    // Clear racing a drop: the drop wins.
    frame(32'd400, 32'd500, 0, 0, 0, 1);
    check_val("race_ovf", 64'(overflow), 64'd1);
    check_val("race_drop", 64'(drop_cnt), 64'd1);
    check_val("race_level", 64'(level), 64'd8);
    drain();
    check_val("race_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with stored pairs.
    for (int k = 0; k < 5; k++) frame(32'(10 + k), 32'(20 + k), 1, 0, 0, 0);
    check_val("pre_rst_level", 64'(level), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check_val("mid_rst_level", 64'(level), 64'd0);
    check_val("mid_rst_valid", 64'(m_valid), 64'd0);
    check_val("mid_rst_ovf", 64'(overflow), 64'd0);

    // Enable dropped between left_done and right_done.
    frame(32'd7, 32'd8, 0, 1, 0, 0);
    check_val("en_drop_level", 64'(level), 64'd0);
    frame(32'd9, 32'd10, 1, 0, 0, 0);
    check_val("en_recover_level", 64'(level), 64'd1);
    drain();
    check_val("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
